// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: packet-based round-robin arbiter sequencing a 2:1 mux between requesters A and B
module mux2_rr_arbiter #(
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic [DW-1:0] data_a,
  input  logic          last_a,
  input  logic          req_b,
  input  logic [DW-1:0] data_b,
  input  logic          last_b,
  input  logic          out_ready,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic [CW-1:0] pkt_cnt_a,
  output logic [CW-1:0] pkt_cnt_b
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, state_nx, arb;
  logic prio, prio_nx, own_a, own_b, done;
  always_comb begin
    own_a     = state == OWN_A;
    own_b     = state == OWN_B;
    out_data  = sel ? data_b : data_a;
    out_last  = sel ? last_b : last_a;
    gnt_a     = own_a & req_a & out_ready;
    gnt_b     = own_b & req_b & out_ready;
    out_valid = (own_a & req_a) | (own_b & req_b);
    done      = (gnt_a | gnt_b) & out_last;
    prio_nx   = done ? own_a : prio;
    arb       = (req_a & (~req_b | ~prio_nx)) ? OWN_A : req_b ? OWN_B : IDLE;
    state_nx  = (state == IDLE || done) ? arb : state;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      sel       <= 1'b0;
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else begin
      state     <= state_nx;
      prio      <= prio_nx;
      sel       <= state_nx == OWN_B;
      pkt_cnt_a <= pkt_cnt_a + CW'(done & own_a);
      pkt_cnt_b <= pkt_cnt_b + CW'(done & own_b);
    end
  end
endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Sequences the 2:1 mux select line so two requesters (A, B) share one output channel.
- Arbitration is packet-based round-robin.
- A grant is held until the granted requester's last beat is accepted downstream.
- Per-requester wrapping packet counters give lab-level observability.

Parameters:
- DW, 8, data width of each requester and of the output channel.
- CW, 8, width of each per-requester completed-packet counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_a  input  1  requester A has a valid beat.
- data_a  input  DW  requester A beat data.
- last_a  input  1  requester A beat is final beat of its packet.
- req_b  input  1  requester B has a valid beat.
- data_b  input  DW  requester B beat data.
- last_b  input  1  requester B beat is final beat of its packet.
- out_ready  input  1  downstream accepts a beat this cycle.
- gnt_a  output  1  beat from A accepted this cycle (ready back to A).
- gnt_b  output  1  beat from B accepted this cycle (ready back to B).
- sel  output  1  mux select: 0 = A, 1 = B.
- out_valid  output  1  output beat valid.
- out_data  output  DW  output beat data.
- out_last  output  1  output beat is last of packet.
- busy  output  1  a packet is in progress (state is not IDLE).
- pkt_cnt_a  output  CW  packets completed by A, wraps modulo 2^CW.
- pkt_cnt_b  output  CW  packets completed by B, wraps modulo 2^CW.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- State register: {IDLE, OWN_A, OWN_B}.
- Priority pointer prio: 0 = A favoured, 1 = B favoured.
- Reset values: state=IDLE, prio=0, sel=0, pkt_cnt_a=0, pkt_cnt_b=0. Consequently out_valid=0, gnt_a=0, gnt_b=0, busy=0.
- sel is a register: 0 in IDLE/OWN_A, 1 in OWN_B.
- Output decode (combinational from registered state):
  - out_data and out_last come from the input selected by sel.
  - out_valid = (OWN_A & req_a) | (OWN_B & req_b); 0 in IDLE.
  - gnt_a = OWN_A & req_a & out_ready; gnt_b = OWN_B & req_b & out_ready.
- Transfer: a beat transfers when out_valid & out_ready. No transfer occurs in IDLE.
- Arbitration function arb(req_a, req_b, prio):
  - only A requesting -> OWN_A; only B requesting -> OWN_B;
  - both requesting -> the side favoured by prio;
  - neither requesting -> IDLE.
- IDLE: next state = arb(...). The first beat therefore has one cycle of latency from req to out_valid.
- OWN_x, transfer with last_x=1:
  - pkt_cnt_x increments;
  - prio is set to favour the other side;
  - next state = arb(...) using the updated prio;
  - back-to-back packets follow with no idle cycle.
- OWN_x, transfer with last_x=0: stay in OWN_x.
- OWN_x, no transfer: stay in OWN_x.
  - A stall (out_ready=0) holds state, and data passes through unchanged.
  - req_x dropping mid-packet does not release the grant; out_valid simply deasserts.
- Requests from the non-owning side are ignored until the owning packet ends. There is no preemption.
- Single active requester: it is re-granted consecutively regardless of prio.
- Counter wrap: at 2^CW-1 the next increment gives 0.
- Reset mid-packet: the packet is abandoned, state returns to IDLE, and the counters clear.
- Inputs are assumed stable while req_x=1 and gnt_x=0; the block does not register data.

Test Plan:
- Reset, then req_a=1 with a 3-beat packet (data 0x11,0x22,0x33; last on the third), out_ready=1:
  - out_valid rises 1 cycle after req;
  - out_data sequence is 0x11,0x22,0x33; sel=0 throughout;
  - pkt_cnt_a=1, then state IDLE.
- req_a and req_b both held high with continuous 2-beat packets, out_ready=1:
  - grants alternate A,B,A,B;
  - no idle cycle between packets;
  - after 4 packets, pkt_cnt_a=2 and pkt_cnt_b=2.
- Mid-packet of A, toggle out_ready=0 for 3 cycles:
  - state stays OWN_A; gnt_a=0 during the stall;
  - out_data holds the same beat;
  - the transfer resumes when out_ready=1.
- B raises req_b during A's 4-beat packet:
  - B is not granted until the cycle after A's last beat transfers;
  - sel flips to 1 exactly then.
- With CW=2, A sends 5 single-beat packets:
  - pkt_cnt_a runs 1,2,3,0,1.
- Assert rst during the second beat of a B packet:
  - next cycle: state IDLE, out_valid=0, sel=0, counters=0;
  - with both requests high after reset, A wins first (prio=0).
